multi_counter_status_q: RTL and testbench

//  Downstream buffer for the multi_counter status interface. Captures every query result
//  (status_pass_r & status_qry_r) into a FIFO and presents it on a valid/ready port.
//  The multi_counter has no backpressure, so this block also issues a query credit
//  (cmd_qry_ok) to the command source, guaranteeing no query result is ever dropped.

---
 rtl/multi_counter_pkg.sv | 16 +
 rtl/multi_counter_status_fifo.sv | 48 ++++
 rtl/multi_counter_status_q.sv | 92 +++++++++
 tb/tb_multi_counter_status_q.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_counter_pkg.sv
// Shared definitions for the multi_counter status path: default widths and the
// field order of a buffered query result.
package multi_counter_pkg;

  localparam int CNTRS_N_DEF = 256;
  localparam int CNTRS_W_DEF = 32;
  localparam int SEQ_W_DEF   = 8;

  // Entry layout MSB-first; users re-declare it at their own parameterised widths.
  typedef struct packed {
    logic [$clog2(CNTRS_N_DEF)-1:0] id;
    logic [CNTRS_W_DEF-1:0]         dat;
    logic [SEQ_W_DEF-1:0]           seq;
  } status_ent_t;

endpackage

// File: rtl/multi_counter_status_fifo.sv
// Circular FIFO of status entries; head is presented straight from storage so a
// write is visible at the output on the following cycle.
module multi_counter_status_fifo #(
  parameter int DEPTH = 8,
  parameter int ENT_W = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [ENT_W-1:0]           wr_ent,
  output logic [ENT_W-1:0]           head,
  output logic                       head_vld,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by occ, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_ent;
  end

  assign head_vld = (occ != '0);
  assign head     = head_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/multi_counter_status_q.sv
// Buffers multi_counter query results and issues query credits so that no
// result is lost despite the counter having no backpressure.
module multi_counter_status_q
  import multi_counter_pkg::*;
#(
  parameter int CNTRS_N    = CNTRS_N_DEF,
  parameter int CNTRS_W    = CNTRS_W_DEF,
  parameter int CNTRS_ID_W = $clog2(CNTRS_N),
  parameter int DEPTH      = 8,
  parameter int SEQ_W      = SEQ_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_qry_issue,
  output logic                       cmd_qry_ok,
  input  logic                       status_pass_r,
  input  logic                       status_qry_r,
  input  logic [CNTRS_ID_W-1:0]      status_id_r,
  input  logic [CNTRS_W-1:0]         status_dat_r,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [CNTRS_ID_W-1:0]      out_id,
  output logic [CNTRS_W-1:0]         out_dat,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic                       ovf_err,
  output logic                       proto_err
);

  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [CNTRS_ID_W-1:0] id;
    logic [CNTRS_W-1:0]    dat;
    logic [SEQ_W-1:0]      seq;
  } ent_t;

  ent_t             wr_ent;
  ent_t             head;
  logic             push, pop, full, accept, drop, inc;
  logic [SEQ_W-1:0] seq;
  logic [OCC_W-1:0] inflight;
  logic [OCC_W:0]   credit_sum;

  assign push   = status_pass_r & status_qry_r;
  assign pop    = out_vld & out_rdy;
  assign full   = (occ == OCC_W'(DEPTH));
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  // Credits cover both queued and still-in-flight results.
  assign credit_sum = {1'b0, occ} + {1'b0, inflight};
  assign cmd_qry_ok = credit_sum < (OCC_W+1)'(DEPTH);
  assign inc        = cmd_qry_issue & cmd_qry_ok;

  assign wr_ent = '{id: status_id_r, dat: status_dat_r, seq: seq};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq       <= '0;
      inflight  <= '0;
      ovf_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (accept) seq <= seq + SEQ_W'(1);
      if (inc && !push)                          inflight <= inflight + OCC_W'(1);
      else if (!inc && push && inflight != '0)   inflight <= inflight - OCC_W'(1);
      if (drop) ovf_err <= 1'b1;
      // A result nobody asked for, or a query beyond the credit window.
      if ((push && inflight == '0) || (cmd_qry_issue && !cmd_qry_ok)) proto_err <= 1'b1;
    end
  end

  multi_counter_status_fifo #(
    .DEPTH (DEPTH),
    .ENT_W ($bits(ent_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept),
    .rd_en    (pop),
    .wr_ent   (wr_ent),
    .head     (head),
    .head_vld (out_vld),
    .occ      (occ)
  );

  assign out_id  = head.id;
  assign out_dat = head.dat;
  assign out_seq = head.seq;

endmodule

// File: tb/tb_multi_counter_status_q.sv
// Randomised and directed check of multi_counter_status_q against a queue-based model.
module tb_multi_counter_status_q;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        cmd_qry_issue;
  logic        cmd_qry_ok;
  logic        status_pass_r;
  logic        status_qry_r;
  logic [7:0]  status_id_r;
  logic [31:0] status_dat_r;
  logic        out_vld;
  logic        out_rdy;
  logic [7:0]  out_id;
  logic [31:0] out_dat;
  logic [7:0]  out_seq;
  logic [3:0]  occ;
  logic        ovf_err;
  logic        proto_err;

  multi_counter_status_q #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_qry_issue (cmd_qry_issue),
    .cmd_qry_ok    (cmd_qry_ok),
    .status_pass_r (status_pass_r),
    .status_qry_r  (status_qry_r),
    .status_id_r   (status_id_r),
    .status_dat_r  (status_dat_r),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .out_id        (out_id),
    .out_dat       (out_dat),
    .out_seq       (out_seq),
    .occ           (occ),
    .ovf_err       (ovf_err),
    .proto_err     (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] dat;
    int          seq;
  } ent_t;

  ent_t m_q[$];
  int   m_inflight;
  int   m_seq;
  bit   m_ovf;
  bit   m_proto;
  bit   chk_en;
  int   tests;
  int   fails;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inflight = 0;
    m_seq      = 0;
    m_ovf      = 0;
    m_proto    = 0;
  endtask

  // Applies the rules to the inputs present at this clock edge.
  task automatic model_step();
    bit   ok, pop, push, inc;
    ent_t e;
    ok   = (m_q.size() + m_inflight) < DEPTH;
    pop  = (m_q.size() != 0) && out_rdy;
    push = status_pass_r && status_qry_r;
    inc  = cmd_qry_issue && ok;
    if (cmd_qry_issue && !ok) m_proto = 1;
    if (push && m_inflight == 0) m_proto = 1;
    if (inc && !push) m_inflight++;
    else if (!inc && push && m_inflight > 0) m_inflight--;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) begin
        e.id  = status_id_r;
        e.dat = status_dat_r;
        e.seq = m_seq;
        m_q.push_back(e);
        m_seq = (m_seq + 1) % 256;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_vld", out_vld, m_q.size() != 0);
      check("occ", occ, m_q.size());
      check("cmd_qry_ok", cmd_qry_ok, (m_q.size() + m_inflight) < DEPTH);
      check("ovf_err", ovf_err, m_ovf);
      check("proto_err", proto_err, m_proto);
      if (m_q.size() != 0) begin
        check("out_id", out_id, m_q[0].id);
        check("out_dat", out_dat, m_q[0].dat);
        check("out_seq", out_seq, m_q[0].seq);
      end
    end
  end

  task automatic cyc(input bit iss, input bit pass, input bit qry, input int id,
                     input logic [31:0] dat, input bit rdy);
    cmd_qry_issue = iss;
    status_pass_r = pass;
    status_qry_r  = qry;
    status_id_r   = id[7:0];
    status_dat_r  = dat;
    out_rdy       = rdy;
    @(posedge clk);
    model_step();
    #1;
    cmd_qry_issue = 0;
    status_pass_r = 0;
    status_qry_r  = 0;
    out_rdy       = 0;
  endtask

  task automatic apply_reset();
    rst = 0;
    #1;
    model_reset();
    chk_en = 1;
    check("rst out_vld", out_vld, 0);
    check("rst occ", occ, 0);
    check("rst cmd_qry_ok", cmd_qry_ok, 1);
    check("rst ovf_err", ovf_err, 0);
    check("rst proto_err", proto_err, 0);
    check("rst out_id", out_id, 0);
    check("rst out_dat", out_dat, 0);
    check("rst out_seq", out_seq, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    bit iss, pass, qry, rdy, ok;
    int id_before;
    tests = 0; fails = 0; chk_en = 0;
    rst = 1; cmd_qry_issue = 0; status_pass_r = 0; status_qry_r = 0;
    status_id_r = 0; status_dat_r = 0; out_rdy = 0;
    model_reset();
    #1;
    apply_reset();

    // Single query round trip
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 5, 32'h2A, 0);
    check("single vld", out_vld, 1);
    check("single id", out_id, 5);
    check("single dat", out_dat, 32'h2A);
    check("single seq", out_seq, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("single pop vld", out_vld, 0);
    check("single pop occ", occ, 0);
    check("single pop ok", cmd_qry_ok, 1);

    // Credit limit
    for (int k = 0; k < 8; k++) cyc(1, 0, 0, 0, 0, 0);
    check("credit ok after 8 issues", cmd_qry_ok, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, 1, 10 + k, k, 0);
    check("credit occ full", occ, 8);
    check("credit ok full", cmd_qry_ok, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("credit ok after pop", cmd_qry_ok, 1);
    check("credit occ after pop", occ, 7);

    // Push and pop together on a full FIFO
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 100, 32'h64, 0);
    check("full occ", occ, 8);
    cyc(0, 1, 1, 3, 32'h3, 1);
    check("full push+pop occ", occ, 8);
    check("full push+pop ovf", ovf_err, 0);
    for (int k = 0; k < 8; k++) begin
      id_before = out_id;
      if (k == 7) check("full id3 emerges 8th", id_before, 3);
      cyc(0, 0, 0, 0, 0, 1);
    end

    // Overflow drop keeps seq
    for (int k = 0; k < 8; k++) cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, 1, 20 + k, 32'h100 + k, 0);
    cyc(0, 1, 1, 99, 32'hDEAD, 0);
    check("ovf sticky", ovf_err, 1);
    check("ovf occ", occ, 8);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 7, 32'h7, 0);
    check("ovf seq unchanged", out_seq, 19);
    cyc(0, 0, 0, 0, 0, 1);

    // Sequence and pointer wrap
    apply_reset();
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) cyc(i < 299, 1, 1, i, i * 3, 1);
    check("wrap last seq", out_seq, 43);
    check("wrap last id", out_id, 43);
    cyc(0, 0, 0, 0, 0, 1);

    // Randomised traffic; protocol abuse only in the second half
    for (int n = 0; n < 3000; n++) begin
      ok  = (m_q.size() + m_inflight) < DEPTH;
      iss = ok ? ($urandom_range(0, 99) < 50) : (n >= 1500 && $urandom_range(0, 49) == 0);
      if (m_inflight > 0) pass = ($urandom_range(0, 99) < 50);
      else                pass = (n >= 1500 && $urandom_range(0, 49) == 0);
      qry = pass;
      if (!pass && $urandom_range(0, 3) == 0) begin
        pass = $urandom_range(0, 1);
        qry  = !pass;
      end
      rdy = ($urandom_range(0, 99) < 60);
      cyc(iss, pass, qry, $urandom_range(0, 255), $urandom, rdy);
    end

    // Asynchronous reset mid-burst
    apply_reset();
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 40 + k, k, 0);
    check("burst occ", occ, 5);
    rst = 0;
    #1;
    check("async out_vld", out_vld, 0);
    check("async occ", occ, 0);
    check("async cmd_qry_ok", cmd_qry_ok, 1);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    cyc(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
